mem_stage_lsu: RTL

// - MEM stage of the 5-stage RISC-V pipeline: consumes the EX/MEM register outputs, runs the data-memory access over a req/ack handshake, and drives the MEM/WB register.
// - Stalls the front of the pipeline while a load or store is outstanding; inserts writeback bubbles during the stall.
// - Non-memory instructions pass through with one register stage of latency.

---
 rtl/mem_stage_lsu_if.sv | 22 ++
 rtl/mem_stage_lsu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: req/ack data-memory port between the MEM stage (master) and data memory (slave).
interface mem_stage_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  memReq;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memWData;
    logic [DATA_WIDTH-1:0] memRData;
    logic                  memAck;

    modport master (
        output memReq, memWe, memAddr, memWData,
        input  memRData, memAck
    );

    modport slave (
        input  memReq, memWe, memAddr, memWData,
        output memRData, memAck
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage of a 5-stage RISC-V pipeline; drives MEM/WB and a req/ack data-memory port.
// Optional feature macro MEM_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES WAIT cycles without memAck.
module mem_stage_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] aluResult_EX_MEM,
    input  logic [DATA_WIDTH-1:0] data2_EX_MEM,
    input  logic [DATA_WIDTH-1:0] returnAddr_EX_MEM,
    input  logic [4:0]            rd_EX_MEM,
    input  logic                  regWrite_EX_MEM,
    input  logic                  memWrite_EX_MEM,
    input  logic                  memRead_EX_MEM,
    input  logic                  memToReg_EX_MEM,
    input  logic                  jump_EX_MEM,
    mem_stage_lsu_if.master       mem,
    output logic                  stall_MEM,
    output logic [DATA_WIDTH-1:0] readData_MEM_WB,
    output logic [DATA_WIDTH-1:0] aluResult_MEM_WB,
    output logic [DATA_WIDTH-1:0] returnAddr_MEM_WB,
    output logic [4:0]            rd_MEM_WB,
    output logic                  regWrite_MEM_WB,
    output logic                  memToReg_MEM_WB,
    output logic                  jump_MEM_WB,
    output logic                  memError_MEM_WB
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("mem_stage_lsu: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] alu_q, alu_d;
    logic [DATA_WIDTH-1:0] ret_q, ret_d;
    logic [4:0]            rd_q, rd_d;
    logic                  rw_q, rw_d;
    logic                  m2r_q, m2r_d;
    logic                  jmp_q, jmp_d;
    logic                  err_q, err_d;

    logic access, is_load, in_wait, timeout, done;

    assign access  = memRead_EX_MEM | memWrite_EX_MEM;
    // Both read and write set is illegal; it behaves as a store, so it never returns load data.
    assign is_load = memRead_EX_MEM & ~memWrite_EX_MEM;
    assign in_wait = (state_q == S_WAIT);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // An ack in the timeout cycle wins, so the abort requires memAck low.
    assign timeout = in_wait & ~mem.memAck & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!in_wait) begin
            cnt_d = '0;
        end else if (!mem.memAck) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign done      = in_wait & (mem.memAck | timeout);
    assign stall_MEM = reset & ((~in_wait & access) | (in_wait & ~done));

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        // Default is a bubble: controls cleared, data fields and rd hold.
        rw_d    = 1'b0;
        m2r_d   = 1'b0;
        jmp_d   = 1'b0;
        err_d   = 1'b0;
        rd_d    = rd_q;
        alu_d   = alu_q;
        ret_d   = ret_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (access) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    we_d    = memWrite_EX_MEM;
                    addr_d  = aluResult_EX_MEM[ADDR_WIDTH-1:0];
                    wdata_d = data2_EX_MEM;
                end else begin
                    rw_d    = regWrite_EX_MEM;
                    m2r_d   = memToReg_EX_MEM;
                    jmp_d   = jump_EX_MEM;
                    rd_d    = rd_EX_MEM;
                    alu_d   = aluResult_EX_MEM;
                    ret_d   = returnAddr_EX_MEM;
                    rdata_d = '0;
                end
            end
            S_WAIT: begin
                if (done) begin
                    // EX/MEM is frozen by the stall, so it still holds the accessing instruction.
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    rw_d    = regWrite_EX_MEM & ~timeout;
                    m2r_d   = memToReg_EX_MEM;
                    jmp_d   = jump_EX_MEM;
                    err_d   = timeout;
                    rd_d    = rd_EX_MEM;
                    alu_d   = aluResult_EX_MEM;
                    ret_d   = returnAddr_EX_MEM;
                    rdata_d = (is_load & mem.memAck) ? mem.memRData : '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            alu_q   <= '0;
            ret_q   <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            jmp_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            ret_q   <= ret_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            m2r_q   <= m2r_d;
            jmp_q   <= jmp_d;
            err_q   <= err_d;
        end
    end

    assign mem.memReq   = req_q;
    assign mem.memWe    = we_q;
    assign mem.memAddr  = addr_q;
    assign mem.memWData = wdata_q;

    assign readData_MEM_WB   = rdata_q;
    assign aluResult_MEM_WB  = alu_q;
    assign returnAddr_MEM_WB = ret_q;
    assign rd_MEM_WB         = rd_q;
    assign regWrite_MEM_WB   = rw_q;
    assign memToReg_MEM_WB   = m2r_q;
    assign jump_MEM_WB       = jmp_q;
    assign memError_MEM_WB   = err_q;

endmodule
